mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MEM stage: issues load/store bus requests, holds them across wait states, aligns/extends data.
// Zero-wait accesses complete in one cycle; o_stall freezes upstream while the bus has not acked.
module mem_access #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic                i_flush,
    input  logic                i_con_mem_read,
    input  logic                i_con_mem_write,
    input  logic                i_con_mem_branch,
    input  logic                i_con_Zero,
    input  logic                i_con_wb_memtoreg,
    input  logic                i_con_wb_regwrite,
    input  logic [1:0]          i_con_size,
    input  logic                i_con_unsigned,
    input  logic [DATA_W-1:0]   i_data_ALU_Rst,
    input  logic [DATA_W-1:0]   i_data_Store,
    input  logic [REG_AW-1:0]   i_addr_MuxRst,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [DATA_W-1:0]   o_mem_addr,
    output logic [DATA_W/8-1:0] o_mem_be,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_stall,
    output logic                o_con_Branch,
    output logic                o_valid,
    output logic                o_con_wb_memtoreg,
    output logic                o_con_wb_regwrite,
    output logic [DATA_W-1:0]   o_data_ALU_Rst,
    output logic [DATA_W-1:0]   o_data_Mem,
    output logic [REG_AW-1:0]   o_addr_MuxRst,
    output logic                o_misalign
);
    localparam int LANES = DATA_W / 8;
    localparam int OFS_W = $clog2(LANES);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   lane_mask = LANES'(1);
            2'b01:   lane_mask = LANES'(3);
            2'b10:   lane_mask = LANES'(15);
            default: lane_mask = '1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [OFS_W-1:0] ofs);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ofs[0];
            2'b10:   misaligned = (ofs[1:0] != 2'b00);
            default: misaligned = (DATA_W == 32) || (ofs != '0);
        endcase
    endfunction

    // Shift the addressed bytes down, then fill the upper bits with sign or zero.
    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rd,
                                                   input logic [OFS_W-1:0]  ofs,
                                                   input logic [1:0]        sz,
                                                   input logic              uns);
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] m;
        logic              sgn;
        s = rd >> {ofs, 3'b000};
        case (sz)
            2'b00:   begin m = DATA_W'(8'hFF);         sgn = s[7];  end
            2'b01:   begin m = DATA_W'(16'hFFFF);      sgn = s[15]; end
            2'b10:   begin m = DATA_W'(32'hFFFF_FFFF); sgn = s[31]; end
            default: begin m = '1;                     sgn = 1'b0;  end
        endcase
        load_ext = (s & m) | ((sgn && !uns) ? ~m : '0);
    endfunction

    state_t              state_q, state_d;
    logic                lat_we_q, lat_we_d;
    logic                lat_rd_q, lat_rd_d;
    logic [LANES-1:0]    lat_be_q, lat_be_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic [1:0]          lat_size_q, lat_size_d;
    logic                lat_uns_q, lat_uns_d;
    logic [DATA_W-1:0]   lat_alu_q, lat_alu_d;
    logic [REG_AW-1:0]   lat_dest_q, lat_dest_d;
    logic                lat_memtoreg_q, lat_memtoreg_d;
    logic                lat_regwrite_q, lat_regwrite_d;
    logic                flush_pend_q, flush_pend_d;
    logic                wb_valid_q, wb_valid_d;
    logic                wb_memtoreg_q, wb_memtoreg_d;
    logic                wb_regwrite_q, wb_regwrite_d;
    logic [DATA_W-1:0]   wb_alu_q, wb_alu_d;
    logic [DATA_W-1:0]   wb_mem_q, wb_mem_d;
    logic [REG_AW-1:0]   wb_dest_q, wb_dest_d;
    logic                misalign_q, misalign_d;

    logic [OFS_W-1:0]    ofs;
    logic                is_rd, is_wr, access, mis_acc, legal, idle_kill, wait_kill;
    logic [DATA_W-1:0]   cur_addr, cur_wdata;
    logic [LANES-1:0]    cur_be;

    assign ofs       = i_data_ALU_Rst[OFS_W-1:0];
    assign is_rd     = i_con_mem_read;
    assign is_wr     = i_con_mem_write & ~i_con_mem_read;
    assign access    = i_valid & (is_rd | is_wr) & ~i_flush;
    assign mis_acc   = access & misaligned(i_con_size, ofs);
    assign legal     = access & ~mis_acc;
    assign idle_kill = ~i_valid | i_flush | mis_acc;
    assign wait_kill = flush_pend_q | i_flush;
    assign cur_addr  = {i_data_ALU_Rst[DATA_W-1:OFS_W], {OFS_W{1'b0}}};
    assign cur_be    = lane_mask(i_con_size) << ofs;
    assign cur_wdata = i_data_Store << {ofs, 3'b000};

    always_comb begin
        state_d        = state_q;
        lat_we_d       = lat_we_q;
        lat_rd_d       = lat_rd_q;
        lat_be_d       = lat_be_q;
        lat_wdata_d    = lat_wdata_q;
        lat_size_d     = lat_size_q;
        lat_uns_d      = lat_uns_q;
        lat_alu_d      = lat_alu_q;
        lat_dest_d     = lat_dest_q;
        lat_memtoreg_d = lat_memtoreg_q;
        lat_regwrite_d = lat_regwrite_q;
        flush_pend_d   = flush_pend_q;
        wb_valid_d     = wb_valid_q;
        wb_memtoreg_d  = wb_memtoreg_q;
        wb_regwrite_d  = wb_regwrite_q;
        wb_alu_d       = wb_alu_q;
        wb_mem_d       = wb_mem_q;
        wb_dest_d      = wb_dest_q;
        misalign_d     = 1'b0;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr     = cur_addr;
        o_mem_be       = '0;
        o_mem_wdata    = cur_wdata;
        o_stall        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_mem_req = legal;
                o_mem_we  = legal & is_wr;
                o_mem_be  = legal ? cur_be : '0;
                if (legal && !i_mem_ack) begin
                    o_stall        = 1'b1;
                    state_d        = ST_WAIT;
                    lat_we_d       = is_wr;
                    lat_rd_d       = is_rd;
                    lat_be_d       = cur_be;
                    lat_wdata_d    = cur_wdata;
                    lat_size_d     = i_con_size;
                    lat_uns_d      = i_con_unsigned;
                    lat_alu_d      = i_data_ALU_Rst;
                    lat_dest_d     = i_addr_MuxRst;
                    lat_memtoreg_d = i_con_wb_memtoreg;
                    lat_regwrite_d = i_con_wb_regwrite;
                    flush_pend_d   = 1'b0;
                end else begin
                    wb_valid_d    = ~idle_kill;
                    wb_regwrite_d = i_con_wb_regwrite & ~idle_kill;
                    wb_memtoreg_d = i_con_wb_memtoreg;
                    wb_alu_d      = i_data_ALU_Rst;
                    wb_dest_d     = i_addr_MuxRst;
                    wb_mem_d      = (legal && is_rd) ?
                                    load_ext(i_mem_rdata, ofs, i_con_size, i_con_unsigned) : '0;
                    misalign_d    = mis_acc;
                end
            end
            ST_WAIT: begin
                // Bus sees only the latched copy; live inputs are don't-care here.
                o_mem_req    = 1'b1;
                o_mem_we     = lat_we_q;
                o_mem_addr   = {lat_alu_q[DATA_W-1:OFS_W], {OFS_W{1'b0}}};
                o_mem_be     = lat_be_q;
                o_mem_wdata  = lat_wdata_q;
                o_stall      = ~i_mem_ack;
                flush_pend_d = wait_kill;
                if (i_mem_ack) begin
                    state_d       = ST_IDLE;
                    flush_pend_d  = 1'b0;
                    wb_valid_d    = ~wait_kill;
                    wb_regwrite_d = lat_regwrite_q & ~wait_kill;
                    wb_memtoreg_d = lat_memtoreg_q;
                    wb_alu_d      = lat_alu_q;
                    wb_dest_d     = lat_dest_q;
                    wb_mem_d      = lat_rd_q ?
                                    load_ext(i_mem_rdata, lat_alu_q[OFS_W-1:0], lat_size_q, lat_uns_q) : '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            lat_we_q       <= 1'b0;
            lat_rd_q       <= 1'b0;
            lat_be_q       <= '0;
            lat_wdata_q    <= '0;
            lat_size_q     <= '0;
            lat_uns_q      <= 1'b0;
            lat_alu_q      <= '0;
            lat_dest_q     <= '0;
            lat_memtoreg_q <= 1'b0;
            lat_regwrite_q <= 1'b0;
            flush_pend_q   <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_alu_q       <= '0;
            wb_mem_q       <= '0;
            wb_dest_q      <= '0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            lat_we_q       <= lat_we_d;
            lat_rd_q       <= lat_rd_d;
            lat_be_q       <= lat_be_d;
            lat_wdata_q    <= lat_wdata_d;
            lat_size_q     <= lat_size_d;
            lat_uns_q      <= lat_uns_d;
            lat_alu_q      <= lat_alu_d;
            lat_dest_q     <= lat_dest_d;
            lat_memtoreg_q <= lat_memtoreg_d;
            lat_regwrite_q <= lat_regwrite_d;
            flush_pend_q   <= flush_pend_d;
            wb_valid_q     <= wb_valid_d;
            wb_memtoreg_q  <= wb_memtoreg_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_alu_q       <= wb_alu_d;
            wb_mem_q       <= wb_mem_d;
            wb_dest_q      <= wb_dest_d;
            misalign_q     <= misalign_d;
        end
    end

    assign o_con_Branch      = i_valid & ~i_flush & i_con_mem_branch & i_con_Zero;
    assign o_valid           = wb_valid_q;
    assign o_con_wb_memtoreg = wb_memtoreg_q;
    assign o_con_wb_regwrite = wb_regwrite_q;
    assign o_data_ALU_Rst    = wb_alu_q;
    assign o_data_Mem        = wb_mem_q;
    assign o_addr_MuxRst     = wb_dest_q;
    assign o_misalign        = misalign_q;
endmodule
